phase_cordic: RTL and testbench

Sequential, time-multiplexed CORDIC phase estimator that sits directly downstream of the 4-channel Hilbert filter. On each sample strobe it snapshots the four analytic pairs (re_k, im_k) and computes each channel's phase, atan2(im, re). The four channels share one vectoring-mode CORDIC datapath that performs one iteration per clock. The resulting binary-angle phases feed the phase-difference / direction-of-arrival logic.

---
 rtl/phase_pkg.sv | 38 +++
 rtl/cordic_iter.sv | 36 +++
 rtl/phase_cordic.sv | 188 ++++++++++++++++++
 tb/tb_phase_cordic.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared types and constants for the phase_cordic CORDIC phase estimator:
// FSM state encoding, data/angle widths, arctangent table and gain constant.
package phase_pkg;

   localparam int DATA_W   = 16;
   localparam int ANG_W    = 16;
   localparam int N_ATAN   = 14;
   localparam int GAIN_Q15 = 19898;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ITER  = 2'd2,
      STORE = 2'd3
   } state_e;

   // round(atan(2^-i) * 32768 / pi) in binary-angle units
   function automatic logic [ANG_W-1:0] atan_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    return 16'd8192;
         4'd1:    return 16'd4836;
         4'd2:    return 16'd2555;
         4'd3:    return 16'd1297;
         4'd4:    return 16'd651;
         4'd5:    return 16'd326;
         4'd6:    return 16'd163;
         4'd7:    return 16'd81;
         4'd8:    return 16'd41;
         4'd9:    return 16'd20;
         4'd10:   return 16'd10;
         4'd11:   return 16'd5;
         4'd12:   return 16'd3;
         4'd13:   return 16'd1;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/cordic_iter.sv
// One combinational vectoring-mode CORDIC micro-rotation; drives y toward 0
// and accumulates the rotated angle in z (z wraps modulo 2^16).
module cordic_iter
   import phase_pkg::*;
#(
   parameter int XW = 18
) (
   input  logic signed [XW-1:0]    x,
   input  logic signed [XW-1:0]    y,
   input  logic        [ANG_W-1:0] z,
   input  logic        [3:0]       i,
   input  logic        [ANG_W-1:0] atan_i,
   output logic signed [XW-1:0]    x_next,
   output logic signed [XW-1:0]    y_next,
   output logic        [ANG_W-1:0] z_next
);

   logic signed [XW-1:0] x_sh;
   logic signed [XW-1:0] y_sh;

   always_comb begin
      // Both shifts come from the pre-update operands.
      x_sh = x >>> i;
      y_sh = y >>> i;
      if (!y[XW-1]) begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + atan_i;
      end else begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - atan_i;
      end
   end

endmodule

// File: rtl/phase_cordic.sv
// Four-channel time-multiplexed CORDIC atan2 estimator, one iteration per clock.
// Define PHASE_MAG_EN to add gain-compensated magnitude outputs mag1..mag4.
module phase_cordic
   import phase_pkg::*;
#(
   parameter int N_ITER  = 12,
   parameter int W_GUARD = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] re1,
   input  logic [DATA_W-1:0] re2,
   input  logic [DATA_W-1:0] re3,
   input  logic [DATA_W-1:0] re4,
   input  logic [DATA_W-1:0] im1,
   input  logic [DATA_W-1:0] im2,
   input  logic [DATA_W-1:0] im3,
   input  logic [DATA_W-1:0] im4,
   output logic [ANG_W-1:0]  ph1,
   output logic [ANG_W-1:0]  ph2,
   output logic [ANG_W-1:0]  ph3,
   output logic [ANG_W-1:0]  ph4,
   output logic              done,
   output logic              overrun
`ifdef PHASE_MAG_EN
   ,
   output logic [DATA_W-1:0] mag1,
   output logic [DATA_W-1:0] mag2,
   output logic [DATA_W-1:0] mag3,
   output logic [DATA_W-1:0] mag4
`endif
);

   localparam int XW = DATA_W + W_GUARD;

   state_e                   state_q, state_d;
   logic [1:0]               ch_q, ch_d;
   logic [3:0]               it_q, it_d;
   logic signed [DATA_W-1:0] re_q [4], re_d [4];
   logic signed [DATA_W-1:0] im_q [4], im_d [4];
   logic signed [XW-1:0]     x_q, x_d, y_q, y_d;
   logic [ANG_W-1:0]         z_q, z_d;
   logic [ANG_W-1:0]         ph_q [4], ph_d [4];
   logic                     done_q, done_d, overrun_q, overrun_d;

   logic signed [XW-1:0]     x_nxt, y_nxt, re_x, im_x;
   logic [ANG_W-1:0]         z_nxt;

   cordic_iter #(.XW(XW)) u_iter (
      .x      (x_q),
      .y      (y_q),
      .z      (z_q),
      .i      (it_q),
      .atan_i (atan_lut(it_q)),
      .x_next (x_nxt),
      .y_next (y_nxt),
      .z_next (z_nxt)
   );

`ifdef PHASE_MAG_EN
   localparam int MW = XW + 17;
   logic signed [MW-1:0] mag_full;
   logic [DATA_W-1:0]    mag_sat;
   logic [DATA_W-1:0]    mag_q [4], mag_d [4];

   // x_final carries the CORDIC gain; scale by 0.60725 in Q15 and clip.
   assign mag_full = (MW'(x_q) * MW'(GAIN_Q15)) >>> 15;
   assign mag_sat  = (mag_full > MW'(32767)) ? 16'h7FFF : mag_full[DATA_W-1:0];
`endif

   assign re_x = {{W_GUARD{re_q[ch_q][DATA_W-1]}}, re_q[ch_q]};
   assign im_x = {{W_GUARD{im_q[ch_q][DATA_W-1]}}, im_q[ch_q]};

   always_comb begin
      // NOTE: every _d takes its _q value first, so no branch can leave one unassigned and infer a latch.
      state_d   = state_q;
      ch_d      = ch_q;
      it_d      = it_q;
      re_d      = re_q;
      im_d      = im_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      ph_d      = ph_q;
      done_d    = 1'b0;
      overrun_d = enable && (state_q != IDLE);
`ifdef PHASE_MAG_EN
      mag_d     = mag_q;
`endif
      case (state_q)
         IDLE: begin
            if (enable) begin
               re_d    = '{re1, re2, re3, re4};
               im_d    = '{im1, im2, im3, im4};
               ch_d    = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // Fold the left half-plane onto the right; z starts at -pi there.
            if (re_q[ch_q][DATA_W-1]) begin
               x_d = -re_x;
               y_d = -im_x;
               z_d = 16'h8000;
            end else begin
               x_d = re_x;
               y_d = im_x;
               z_d = '0;
            end
            it_d    = '0;
            state_d = ITER;
         end
         ITER: begin
            x_d = x_nxt;
            y_d = y_nxt;
            z_d = z_nxt;
            if (it_q == 4'(N_ITER - 1)) begin
               state_d = STORE;
            end else begin
               it_d = it_q + 4'd1;
            end
         end
         STORE: begin
            ph_d[ch_q] = (re_q[ch_q] == '0 && im_q[ch_q] == '0) ? '0 : z_q;
`ifdef PHASE_MAG_EN
            mag_d[ch_q] = mag_sat;
`endif
            if (ch_q == 2'd3) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               ch_d    = ch_q + 2'd1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         it_q      <= '0;
         ph_q      <= '{default: '0};
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef PHASE_MAG_EN
         mag_q     <= '{default: '0};
`endif
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         it_q      <= it_d;
         ph_q      <= ph_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
`ifdef PHASE_MAG_EN
         mag_q     <= mag_d;
`endif
      end
   end

   // NOTE: snapshot and datapath registers stay unreset; each is written before it is read.
   always_ff @(posedge clock) begin
      re_q <= re_d;
      im_q <= im_d;
      x_q  <= x_d;
      y_q  <= y_d;
      z_q  <= z_d;
   end

   assign ph1     = ph_q[0];
   assign ph2     = ph_q[1];
   assign ph3     = ph_q[2];
   assign ph4     = ph_q[3];
   assign done    = done_q;
   assign overrun = overrun_q;
`ifdef PHASE_MAG_EN
   assign mag1    = mag_q[0];
   assign mag2    = mag_q[1];
   assign mag3    = mag_q[2];
   assign mag4    = mag_q[3];
`endif

endmodule

// File: tb/tb_phase_cordic.sv
// Self-checking bench for phase_cordic: phases compared with an ideal atan2
// model; latency, overrun, reset and (with PHASE_MAG_EN) magnitude also checked.
module tb_phase_cordic;

   localparam int N_ITER  = 12;
   localparam int CH_CYC  = N_ITER + 2;
   // 12 iterations leave a residual of about atan(2^-11) (5 LSB) plus
   // truncation in x/y; at |v|~1000 one y LSB is already ~6 angle LSB.
   localparam int TOL     = 12;
   localparam int MAG_TOL = 6;

   logic               clock = 1'b0;
   logic               reset;
   logic               enable;
   logic signed [15:0] re_v [4];
   logic signed [15:0] im_v [4];
   logic [15:0]        ph1, ph2, ph3, ph4;
   logic               done, overrun;
`ifdef PHASE_MAG_EN
   logic [15:0]        mag1, mag2, mag3, mag4;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int ovr_cnt;
   int exp_ph [4];
   int exp_mag [4];

   always #5 clock = ~clock;

   phase_cordic #(.N_ITER(N_ITER), .W_GUARD(2)) dut (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable),
      .re1     (re_v[0]),
      .re2     (re_v[1]),
      .re3     (re_v[2]),
      .re4     (re_v[3]),
      .im1     (im_v[0]),
      .im2     (im_v[1]),
      .im3     (im_v[2]),
      .im4     (im_v[3]),
      .ph1     (ph1),
      .ph2     (ph2),
      .ph3     (ph3),
      .ph4     (ph4),
      .done    (done),
      .overrun (overrun)
`ifdef PHASE_MAG_EN
      ,
      .mag1    (mag1),
      .mag2    (mag2),
      .mag3    (mag3),
      .mag4    (mag4)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] ph_out(input int k);
      case (k)
         0:       return ph1;
         1:       return ph2;
         2:       return ph3;
         default: return ph4;
      endcase
   endfunction

`ifdef PHASE_MAG_EN
   function automatic logic [15:0] mag_out(input int k);
      case (k)
         0:       return mag1;
         1:       return mag2;
         2:       return mag3;
         default: return mag4;
      endcase
   endfunction
`endif

   // Ideal phase: atan2 scaled to 32768 per pi, rounded, +pi folded onto -32768.
   function automatic int ref_phase(input int re, input int im);
      real a;
      int  p;
      if (re == 0 && im == 0) return 0;
      a = $atan2(real'(im), real'(re)) * 32768.0 / 3.14159265358979;
      p = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
      if (p >= 32768) p -= 65536;
      return p;
   endfunction

   function automatic int ref_mag(input int re, input int im);
      real m;
      int  r;
      m = $sqrt(real'(re) * real'(re) + real'(im) * real'(im));
      r = $rtoi(m + 0.5);
      return (r > 32767) ? 32767 : r;
   endfunction

   // Angular distance modulo 2^16, so -32768 and +32767 are 1 LSB apart.
   function automatic int ang_err(input logic [15:0] got, input int e);
      int d;
      d = int'($signed(got)) - e;
      while (d > 32767) d -= 65536;
      while (d < -32768) d += 65536;
      return d;
   endfunction

   task automatic check_eq(input string tag, input int got, input int e);
      n_chk++;
      assert (got === e) n_pass++;
      else $error("FAIL %s: got %0d required %0d", tag, got, e);
   endtask

   task automatic check_ph(input string tag, input logic [15:0] got, input int e);
      int d;
      bit in_tol;
      d      = ang_err(got, e);
      in_tol = (d >= -TOL) && (d <= TOL);
      n_chk++;
      assert (in_tol === 1'b1) n_pass++;
      else $error("FAIL %s: ph=%0d required=%0d +-%0d", tag, $signed(got), e, TOL);
   endtask

   function automatic int rnd_comp();
      return int'($signed(16'($urandom)));
   endfunction

   task automatic rnd_inputs();
      for (int k = 0; k < 4; k++) begin
         re_v[k] = 16'(rnd_comp());
         im_v[k] = 16'(rnd_comp());
         if ((re_v[k] > -2048) && (re_v[k] < 2048) && (im_v[k] > -2048) && (im_v[k] < 2048))
            re_v[k] = 16'sd20000;
      end
   endtask

   task automatic snap_expect();
      for (int k = 0; k < 4; k++) begin
         exp_ph[k]  = ref_phase(int'(re_v[k]), int'(im_v[k]));
         exp_mag[k] = ref_mag(int'(re_v[k]), int'(im_v[k]));
      end
   endtask

   task automatic pulse_enable();
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   // Called just after the edge that sampled enable. inject_at >= 0 raises a
   // second enable for the edge inject_at+1 with fresh inputs.
   task automatic wait_done(input string tag, input int inject_at);
      int n;
      bit seen;
      n       = 0;
      seen    = 1'b0;
      ovr_cnt = 0;
      if (inject_at < 0) rnd_inputs();
      while (!seen && n < 4 * CH_CYC + 40) begin
         tick();
         n++;
         if (overrun) ovr_cnt++;
         for (int k = 0; k < 4; k++)
            if (n == (k + 1) * CH_CYC)
               check_ph($sformatf("%s ph%0d at edge %0d", tag, k + 1, n), ph_out(k), exp_ph[k]);
         if (n == inject_at) begin
            rnd_inputs();
            enable = 1'b1;
         end else if (inject_at >= 0 && n == inject_at + 1) begin
            enable = 1'b0;
            check_eq({tag, " overrun on busy enable"}, int'(overrun), 1);
         end
         if (done) seen = 1'b1;
      end
      check_eq({tag, " done latency"}, n, 4 * CH_CYC);
      check_eq({tag, " overrun pulse count"}, ovr_cnt, (inject_at >= 0) ? 1 : 0);
`ifdef PHASE_MAG_EN
      for (int k = 0; k < 4; k++) begin
         int d;
         bit in_tol;
         d      = int'(mag_out(k)) - exp_mag[k];
         in_tol = (d >= -MAG_TOL) && (d <= MAG_TOL);
         n_chk++;
         assert (in_tol === 1'b1) n_pass++;
         else $error("FAIL %s mag%0d: got %0d required %0d +-%0d", tag, k + 1, mag_out(k), exp_mag[k], MAG_TOL);
      end
`endif
   endtask

   task automatic apply(input string tag, input int r0, input int i0, input int r1, input int i1,
                        input int r2, input int i2, input int r3, input int i3);
      re_v[0] = 16'(r0); im_v[0] = 16'(i0);
      re_v[1] = 16'(r1); im_v[1] = 16'(i1);
      re_v[2] = 16'(r2); im_v[2] = 16'(i2);
      re_v[3] = 16'(r3); im_v[3] = 16'(i3);
      snap_expect();
      pulse_enable();
      wait_done(tag, -1);
      tick();
      check_eq({tag, " done width"}, int'(done), 0);
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 4; k++)
         check_eq($sformatf("%s ph%0d", tag, k + 1), int'(ph_out(k)), 0);
      check_eq({tag, " done"}, int'(done), 0);
      check_eq({tag, " overrun"}, int'(overrun), 0);
`ifdef PHASE_MAG_EN
      for (int k = 0; k < 4; k++)
         check_eq($sformatf("%s mag%0d", tag, k + 1), int'(mag_out(k)), 0);
`endif
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         re_v[k] = '0;
         im_v[k] = '0;
      end
      repeat (3) tick();
      check_all_zero("reset state");
      reset = 1'b0;
      tick();

      // Axis inputs on all channels.
      apply("axis +re",  1000,     0,  1000,     0,  1000,     0,  1000,     0);
      apply("axis +im",     0,  1000,     0,  1000,     0,  1000,     0,  1000);
      apply("axis -re", -1000,     0, -1000,     0, -1000,     0, -1000,     0);
      apply("axis -im",     0, -1000,     0, -1000,     0, -1000,     0, -1000);

      // One diagonal per quadrant.
      apply("quadrants", 1000, 1000, -1000, 1000, -1000, -1000, 1000, -1000);

      // Either side of the +-pi cut, the zero vector and a plain +re input.
      apply("branch cut", -30000, 1, -30000, -1, 0, 0, 30000, 0);

      // Magnitude references plus full-scale corner.
      apply("magnitude", 3000, 4000, -32768, -32768, 0, 0, -3000, -4000);

      for (int r = 0; r < 6; r++) begin
         rnd_inputs();
         apply($sformatf("random %0d", r), int'(re_v[0]), int'(im_v[0]), int'(re_v[1]), int'(im_v[1]),
               int'(re_v[2]), int'(im_v[2]), int'(re_v[3]), int'(im_v[3]));
      end

      // Busy enable 20 cycles in: overrun pulses, first snapshot survives;
      // the inputs left behind are then accepted on the done cycle.
      rnd_inputs();
      snap_expect();
      pulse_enable();
      wait_done("busy enable", 19);
      snap_expect();
      pulse_enable();
      wait_done("enable on done", -1);
      tick();
      check_eq("enable on done width", int'(done), 0);

      // Reset at cycle 30 of a run, then a clean run.
      rnd_inputs();
      snap_expect();
      pulse_enable();
      repeat (29) tick();
      reset = 1'b1;
      tick();
      check_all_zero("mid-run reset");
      reset = 1'b0;
      tick();
      apply("after reset", 2000, -7000, -12000, 500, 25000, 25000, -400, -9000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
